ctrl_reg_bank: RTL and testbench

Parametrised bank of bus-writable control registers with a command queue, for the IO controller path that drives the robots. Each bus write updates a shadow register, which is continuously visible to the datapath. The same write also pushes a {register index, data} command into a FIFO, which a downstream consumer drains with a valid/ready handshake. Registered readback and a one-cycle `done` pulse per accepted command complete the bus side.

---
 rtl/ctrl_reg_bank.sv | 113 +++++++++++
 tb/tb_ctrl_reg_bank.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_reg_bank.sv
// Bus-writable shadow control registers with a show-ahead command queue for the robot IO path.
// Optional CTRL_BANK_STATUS_EN maps a status register (overflow, fifo_count) at address NUM_REGS.
module ctrl_reg_bank #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REGS   = 4,
   parameter int ADDR_WIDTH = 3,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           we,
   input  logic                           re,
   input  logic [ADDR_WIDTH-1:0]          addr,
   input  logic [DATA_WIDTH-1:0]          wr_data,
   output logic [DATA_WIDTH-1:0]          rd_data,
   output logic                           rd_valid,
   output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
   output logic                           cmd_valid,
   input  logic                           cmd_ready,
   output logic [ADDR_WIDTH-1:0]          cmd_reg,
   output logic [DATA_WIDTH-1:0]          cmd_data,
   output logic                           done,
   output logic                           overflow,
   output logic [$clog2(FIFO_DEPTH):0]    fifo_count
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int CMD_W = ADDR_WIDTH + DATA_WIDTH;
   localparam logic [CNT_W-1:0]      FULL_CNT = CNT_W'(FIFO_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] NREG_A   = ADDR_WIDTH'(NUM_REGS);

   logic [DATA_WIDTH-1:0] shadow [NUM_REGS];
   logic [CMD_W-1:0]      mem    [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr, rd_ptr;
   logic [CNT_W-1:0]      count;
   logic                  addr_ok, wr_reg, pop, full, push, drop;
   logic                  is_status, ovf_clr;
   logic [DATA_WIDTH-1:0] rd_mux;

`ifdef CTRL_BANK_STATUS_EN
   assign is_status = (addr == NREG_A);
`else
   assign is_status = 1'b0;
`endif

   assign addr_ok   = (addr < NREG_A);
   assign wr_reg    = we && addr_ok;
   assign cmd_valid = (count != '0);
   assign pop       = cmd_valid && cmd_ready;
   assign full      = (count == FULL_CNT);
   // A full queue still accepts a push when the head leaves in the same cycle
   assign push      = wr_reg && (!full || pop);
   assign drop      = wr_reg && full && !pop;
   assign ovf_clr   = we && is_status;

   assign {cmd_reg, cmd_data} = mem[rd_ptr];
   assign fifo_count          = count;

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
      assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = shadow[g];
   end

   always_comb begin
      rd_mux = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (addr == ADDR_WIDTH'(i)) rd_mux = shadow[i];
      end
      if (is_status) begin
         rd_mux[DATA_WIDTH-1] = overflow;
         rd_mux[CNT_W-1:0]    = count;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) shadow[i] <= '0;
      end else if (wr_reg) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (addr == ADDR_WIDTH'(i)) shadow[i] <= wr_data;
         end
      end
   end

   // Queue storage carries no reset; occupancy is tracked by count alone
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {addr, wr_data};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         done     <= 1'b0;
         overflow <= 1'b0;
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
         done <= push;
         // A new drop wins over a status clear in the same cycle
         if (drop)         overflow <= 1'b1;
         else if (ovf_clr) overflow <= 1'b0;
         rd_valid <= re;
         if (re) rd_data <= rd_mux;
      end
   end

endmodule

// File: tb/tb_ctrl_reg_bank.sv
// Directed bench for ctrl_reg_bank: vector table for single-cycle behaviour plus
// hand sequences for overflow, drain order, optional status register and async reset.
module tb_ctrl_reg_bank;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          we, re, cmd_ready;
   logic [2:0]    addr;
   logic [31:0]   wr_data;
   logic [31:0]   rd_data;
   logic          rd_valid;
   logic [127:0]  reg_out;
   logic          cmd_valid;
   logic [2:0]    cmd_reg;
   logic [31:0]   cmd_data;
   logic          done;
   logic          overflow;
   logic [3:0]    fifo_count;

   int tests = 0;
   int fails = 0;

   ctrl_reg_bank #(
      .DATA_WIDTH(32),
      .NUM_REGS(4),
      .ADDR_WIDTH(3),
      .FIFO_DEPTH(8)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .we(we),
      .re(re),
      .addr(addr),
      .wr_data(wr_data),
      .rd_data(rd_data),
      .rd_valid(rd_valid),
      .reg_out(reg_out),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_reg(cmd_reg),
      .cmd_data(cmd_data),
      .done(done),
      .overflow(overflow),
      .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic        re;
      logic [2:0]  addr;
      logic [31:0] wdata;
      logic        rdy;
      logic        done;
      logic        ovf;
      logic [3:0]  cnt;
      logic        cv;
      logic        rv;
      logic [31:0] rd;
      logic [1:0]  ridx;
      logic [31:0] rval;
      logic        chk_head;
      logic [2:0]  hreg;
      logic [31:0] hdata;
   } vec_t;

   vec_t vecs [17];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] get_reg(input int i);
      return reg_out[i*32 +: 32];
   endfunction

   task automatic drive(input logic w, input logic r, input logic [2:0] a,
                        input logic [31:0] d, input logic rdy);
      we = w; re = r; addr = a; wr_data = d; cmd_ready = rdy;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      drive(1'b0, 1'b0, 3'd0, 32'd0, 1'b0);
   endtask

   logic [2:0]  q_reg  [8];
   logic [31:0] q_data [8];

   initial begin
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 3'd0, 32'd0, 1'b0);

      vecs[0]  = '{1'b1, 1'b0, 3'd2, 32'hA5, 1'b0,  1'b1, 1'b0, 4'd1, 1'b1, 1'b0, 32'h0,
                   2'd2, 32'hA5, 1'b1, 3'd2, 32'hA5};
      vecs[1]  = '{1'b0, 1'b0, 3'd0, 32'h0, 1'b1,   1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 32'h0,
                   2'd2, 32'hA5, 1'b0, 3'd0, 32'h0};
      for (int k = 0; k < 8; k++) begin
         vecs[2+k] = '{1'b1, 1'b0, 3'(k % 4), 32'(32'h100 + k), 1'b0,
                       1'b1, 1'b0, 4'(k + 1), 1'b1, 1'b0, 32'h0,
                       2'(k % 4), 32'(32'h100 + k), 1'b1, 3'd0, 32'h100};
      end
      vecs[10] = '{1'b1, 1'b0, 3'd1, 32'h55, 1'b1,  1'b1, 1'b0, 4'd8, 1'b1, 1'b0, 32'h0,
                   2'd1, 32'h55, 1'b1, 3'd1, 32'h101};
      vecs[11] = '{1'b1, 1'b1, 3'd3, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 4'd8, 1'b1, 1'b1, 32'h107,
                   2'd3, 32'hDEADBEEF, 1'b1, 3'd2, 32'h102};
      vecs[12] = '{1'b0, 1'b1, 3'd3, 32'h0, 1'b1,   1'b0, 1'b0, 4'd7, 1'b1, 1'b1, 32'hDEADBEEF,
                   2'd3, 32'hDEADBEEF, 1'b1, 3'd3, 32'h103};
      vecs[13] = '{1'b1, 1'b0, 3'd7, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 4'd7, 1'b1, 1'b0, 32'h0,
                   2'd3, 32'hDEADBEEF, 1'b1, 3'd3, 32'h103};
      vecs[14] = '{1'b0, 1'b1, 3'd7, 32'h0, 1'b0,   1'b0, 1'b0, 4'd7, 1'b1, 1'b1, 32'h0,
                   2'd1, 32'h55, 1'b1, 3'd3, 32'h103};
      vecs[15] = '{1'b1, 1'b0, 3'd4, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 4'd7, 1'b1, 1'b0, 32'h0,
                   2'd2, 32'h106, 1'b1, 3'd3, 32'h103};
      vecs[16] = '{1'b0, 1'b1, 3'd0, 32'h0, 1'b0,   1'b0, 1'b0, 4'd7, 1'b1, 1'b1, 32'h104,
                   2'd0, 32'h104, 1'b1, 3'd3, 32'h103};

      q_reg  = '{3'd3, 3'd0, 3'd1, 3'd2, 3'd3, 3'd1, 3'd3, 3'd1};
      q_data = '{32'h103, 32'h104, 32'h105, 32'h106, 32'h107, 32'h55, 32'hDEADBEEF, 32'h1234};

      repeat (2) @(posedge clk);
      #1;
      check("reset_count",    64'(fifo_count), 64'd0);
      check("reset_cmd_valid", 64'(cmd_valid), 64'd0);
      check("reset_done",     64'(done), 64'd0);
      check("reset_overflow", 64'(overflow), 64'd0);
      check("reset_rd_valid", 64'(rd_valid), 64'd0);
      check("reset_rd_data",  64'(rd_data), 64'd0);
      check("reset_reg_out",  64'(|reg_out), 64'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 17; i++) begin
         drive(vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wdata, vecs[i].rdy);
         step();
         check($sformatf("v%0d_done", i),      64'(done), 64'(vecs[i].done));
         check($sformatf("v%0d_overflow", i),  64'(overflow), 64'(vecs[i].ovf));
         check($sformatf("v%0d_count", i),     64'(fifo_count), 64'(vecs[i].cnt));
         check($sformatf("v%0d_cmd_valid", i), 64'(cmd_valid), 64'(vecs[i].cv));
         check($sformatf("v%0d_rd_valid", i),  64'(rd_valid), 64'(vecs[i].rv));
         if (vecs[i].rv)
            check($sformatf("v%0d_rd_data", i), 64'(rd_data), 64'(vecs[i].rd));
         check($sformatf("v%0d_reg%0d", i, vecs[i].ridx), 64'(get_reg(int'(vecs[i].ridx))),
               64'(vecs[i].rval));
         if (vecs[i].chk_head) begin
            check($sformatf("v%0d_cmd_reg", i),  64'(cmd_reg), 64'(vecs[i].hreg));
            check($sformatf("v%0d_cmd_data", i), 64'(cmd_data), 64'(vecs[i].hdata));
         end
      end

      // Fill to the brim, then a dropped push still updates its register
      drive(1'b1, 1'b0, 3'd1, 32'h1234, 1'b0);
      step();
      check("fill_done",  64'(done), 64'd1);
      check("fill_count", 64'(fifo_count), 64'd8);
      drive(1'b1, 1'b0, 3'd2, 32'h77, 1'b0);
      step();
      check("drop_done",     64'(done), 64'd0);
      check("drop_overflow", 64'(overflow), 64'd1);
      check("drop_count",    64'(fifo_count), 64'd8);
      check("drop_reg2",     64'(get_reg(2)), 64'h77);

`ifdef CTRL_BANK_STATUS_EN
      drive(1'b0, 1'b1, 3'd4, 32'h0, 1'b0);
      step();
      check("status_rd_data", 64'(rd_data), 64'h80000008);
      drive(1'b1, 1'b0, 3'd4, 32'hFFFFFFFF, 1'b0);
      step();
      check("status_clr_overflow", 64'(overflow), 64'd0);
      check("status_clr_done",     64'(done), 64'd0);
      check("status_clr_count",    64'(fifo_count), 64'd8);
`endif

      for (int j = 0; j < 8; j++) begin
         check($sformatf("drain%0d_cmd_valid", j), 64'(cmd_valid), 64'd1);
         check($sformatf("drain%0d_cmd_reg", j),   64'(cmd_reg), 64'(q_reg[j]));
         check($sformatf("drain%0d_cmd_data", j),  64'(cmd_data), 64'(q_data[j]));
         drive(1'b0, 1'b0, 3'd0, 32'd0, 1'b1);
         step();
      end
      check("drained_cmd_valid", 64'(cmd_valid), 64'd0);
      check("drained_count",     64'(fifo_count), 64'd0);
`ifdef CTRL_BANK_STATUS_EN
      check("drained_overflow",  64'(overflow), 64'd0);
`else
      check("drained_overflow",  64'(overflow), 64'd1);
`endif

      // Asynchronous reset in the middle of a cycle with a queued command
      drive(1'b1, 1'b0, 3'd0, 32'hAB, 1'b0);
      step();
      check("pre_rst_count", 64'(fifo_count), 64'd1);
      check("pre_rst_done",  64'(done), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_count",     64'(fifo_count), 64'd0);
      check("async_rst_cmd_valid", 64'(cmd_valid), 64'd0);
      check("async_rst_done",      64'(done), 64'd0);
      check("async_rst_overflow",  64'(overflow), 64'd0);
      check("async_rst_reg0",      64'(get_reg(0)), 64'd0);
      #3;
      rst_n = 1'b1;
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
